// File: rtl/aq_djpeg_bitfeed.sv
// Entropy-segment bit feeder: unstuffs 0xFF00, detects markers and keeps a
// left-aligned bit window whose top 32 bits feed the Huffman decoder.
module aq_djpeg_bitfeed #(
  parameter int BUF_BITS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ProcessInit,
  input  logic        ScanStart,
  input  logic        ByteInEnable,
  input  logic [7:0]  ByteIn,
  output logic        ByteInReady,
  input  logic        DecodeUseBit,
  input  logic [6:0]  DecodeUseWidth,
  output logic        DataInRun,
  output logic        DataInEnable,
  output logic [31:0] DataIn,
  output logic [6:0]  BitCount,
  output logic        MarkerDetect,
  output logic [7:0]  MarkerCode,
  input  logic        MarkerClear,
  output logic        ErrorOverUse
);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_FFSEEN, S_MARKER, S_DONE
  } state_e;

  localparam logic [6:0] LOAD_LIM = 7'(BUF_BITS - 8);

  state_e              st_q, st_d;
  logic [BUF_BITS-1:0] win_q, win_d, win_c, app_v;
  logic [6:0]          cnt_q, cnt_d, cnt_c;
  logic [7:0]          code_q, code_d, app_b;
  logic                err_q, err_d;
  logic                acc, app_en, clr;

  assign ByteInReady  = (st_q == S_RUN || st_q == S_FFSEEN)
                        && (cnt_q <= LOAD_LIM);
  assign acc          = ByteInEnable & ByteInReady;
  assign DataInRun    = (st_q != S_IDLE) && (st_q != S_DONE);
  assign DataIn       = win_q[BUF_BITS-1 -: 32];
  assign BitCount     = cnt_q;
  assign MarkerDetect = (st_q == S_MARKER);
  assign MarkerCode   = code_q;
  assign ErrorOverUse = err_q;

  always_comb begin
    case (st_q)
      S_RUN, S_FFSEEN: DataInEnable = (cnt_q >= 7'd32);
      S_MARKER:        DataInEnable = (cnt_q != 7'd0);
      default:         DataInEnable = 1'b0;
    endcase
  end

  always_comb begin
    win_c  = win_q;
    cnt_c  = cnt_q;
    err_d  = err_q;
    st_d   = st_q;
    code_d = code_q;
    app_en = 1'b0;
    app_b  = ByteIn;
    clr    = 1'b0;

    // Consume is applied before the append so a byte lands at the new tail.
    if (DecodeUseBit && DecodeUseWidth != 7'd0) begin
      if (DecodeUseWidth > cnt_q) begin
        win_c = '0;
        cnt_c = 7'd0;
        err_d = 1'b1;
      end else begin
        win_c = win_q << DecodeUseWidth;
        cnt_c = cnt_q - DecodeUseWidth;
      end
    end

    case (st_q)
      S_IDLE: if (ScanStart) st_d = S_RUN;
      S_RUN: begin
        if (acc) begin
          if (ByteIn == 8'hFF) st_d = S_FFSEEN;
          else app_en = 1'b1;
        end
      end
      S_FFSEEN: begin
        if (acc) begin
          if (ByteIn == 8'h00) begin
            app_en = 1'b1;
            app_b  = 8'hFF;
            st_d   = S_RUN;
          end else if (ByteIn != 8'hFF) begin
            code_d = ByteIn;
            st_d   = S_MARKER;
          end
        end
      end
      S_MARKER: begin
        if (MarkerClear) begin
          clr  = 1'b1;
          st_d = (code_q == 8'hD9) ? S_DONE : S_RUN;
        end
      end
      default: ;
    endcase

    app_v = {app_b, {(BUF_BITS-8){1'b0}}} >> cnt_c;
    win_d = app_en ? (win_c | app_v) : win_c;
    cnt_d = app_en ? (cnt_c + 7'd8) : cnt_c;

    if (clr) begin
      win_d = '0;
      cnt_d = 7'd0;
    end

    if (ProcessInit) begin
      st_d   = S_IDLE;
      win_d  = '0;
      cnt_d  = 7'd0;
      code_d = 8'h00;
      err_d  = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= S_IDLE;
      win_q  <= '0;
      cnt_q  <= 7'd0;
      code_q <= 8'h00;
      err_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      win_q  <= win_d;
      cnt_q  <= cnt_d;
      code_q <= code_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_aq_djpeg_bitfeed.sv
// Directed bench for aq_djpeg_bitfeed: unstuffing, markers, consume
// arithmetic, window limits and reset behaviour.
module tb_aq_djpeg_bitfeed;

  logic        clk = 1'b0;
  logic        rst, ProcessInit, ScanStart;
  logic        ByteInEnable, ByteInReady;
  logic [7:0]  ByteIn;
  logic        DecodeUseBit;
  logic [6:0]  DecodeUseWidth;
  logic        DataInRun, DataInEnable;
  logic [31:0] DataIn;
  logic [6:0]  BitCount;
  logic        MarkerDetect;
  logic [7:0]  MarkerCode;
  logic        MarkerClear, ErrorOverUse;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  aq_djpeg_bitfeed #(.BUF_BITS(64)) dut (
    .clk(clk), .rst(rst), .ProcessInit(ProcessInit),
    .ScanStart(ScanStart), .ByteInEnable(ByteInEnable),
    .ByteIn(ByteIn), .ByteInReady(ByteInReady),
    .DecodeUseBit(DecodeUseBit), .DecodeUseWidth(DecodeUseWidth),
    .DataInRun(DataInRun), .DataInEnable(DataInEnable),
    .DataIn(DataIn), .BitCount(BitCount),
    .MarkerDetect(MarkerDetect), .MarkerCode(MarkerCode),
    .MarkerClear(MarkerClear), .ErrorOverUse(ErrorOverUse)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] b);
    ByteInEnable = 1'b1;
    ByteIn = b;
    step();
    ByteInEnable = 1'b0;
  endtask

  task automatic use_bits(input logic [6:0] w);
    DecodeUseBit = 1'b1;
    DecodeUseWidth = w;
    step();
    DecodeUseBit = 1'b0;
    DecodeUseWidth = 7'd0;
  endtask

  task automatic start();
    ScanStart = 1'b1;
    step();
    ScanStart = 1'b0;
  endtask

  task automatic init();
    ProcessInit = 1'b1;
    step();
    ProcessInit = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ProcessInit = 1'b0; ScanStart = 1'b0;
    ByteInEnable = 1'b0; ByteIn = 8'h00;
    DecodeUseBit = 1'b0; DecodeUseWidth = 7'd0;
    MarkerClear = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_cnt", BitCount, 0);
    chk("rst_data", DataIn, 0);
    chk("rst_run", DataInRun, 0);
    chk("rst_rdy", ByteInReady, 0);
    chk("rst_err", ErrorOverUse, 0);

    start();
    chk("run", DataInRun, 1);
    chk("rdy", ByteInReady, 1);

    put(8'h12); put(8'h34); put(8'h56);
    chk("en_24", DataInEnable, 0);
    put(8'h78);
    chk("en_32", DataInEnable, 1);
    chk("data_32", DataIn, 32'h12345678);
    put(8'h9A);
    chk("cnt_40", BitCount, 40);
    chk("data_40", DataIn, 32'h12345678);

    use_bits(7'd4);
    chk("c4_data", DataIn, 32'h23456789);
    chk("c4_cnt", BitCount, 36);
    use_bits(7'd12);
    chk("c12_data", DataIn, 32'h56789A00);
    chk("c12_cnt", BitCount, 24);

    DecodeUseBit = 1'b1; DecodeUseWidth = 7'd8;
    put(8'hBC);
    DecodeUseBit = 1'b0; DecodeUseWidth = 7'd0;
    chk("sim_cnt", BitCount, 24);
    chk("sim_data", DataIn, 32'h789ABC00);

    init();
    chk("init_cnt", BitCount, 0);
    chk("init_run", DataInRun, 0);
    start();
    put(8'hAB); put(8'hFF);
    chk("ff_cnt", BitCount, 8);
    chk("ff_rdy", ByteInReady, 1);
    put(8'h00); put(8'hCD); put(8'hEF); put(8'h01);
    chk("stuf_cnt", BitCount, 40);
    chk("stuf_data", DataIn, 32'hABFFCDEF);

    use_bits(7'd32);
    chk("tail_data", DataIn, 32'h01000000);
    put(8'hFF); put(8'hFF); put(8'hD3);
    chk("mk_det", MarkerDetect, 1);
    chk("mk_code", MarkerCode, 8'hD3);
    chk("mk_rdy", ByteInReady, 0);
    chk("mk_en", DataInEnable, 1);
    chk("mk_cnt", BitCount, 8);
    use_bits(7'd4);
    chk("mk_c4", DataIn, 32'h10000000);
    MarkerClear = 1'b1; DecodeUseBit = 1'b1; DecodeUseWidth = 7'd2;
    step();
    MarkerClear = 1'b0; DecodeUseBit = 1'b0; DecodeUseWidth = 7'd0;
    chk("clr_cnt", BitCount, 0);
    chk("clr_det", MarkerDetect, 0);
    chk("clr_run", DataInRun, 1);
    chk("clr_rdy", ByteInReady, 1);

    put(8'h3C); put(8'h5D);
    use_bits(7'd6);
    chk("ou_pre", BitCount, 10);
    chk("ou_pre_err", ErrorOverUse, 0);
    use_bits(7'd16);
    chk("ou_err", ErrorOverUse, 1);
    chk("ou_cnt", BitCount, 0);

    for (int i = 0; i < 7; i++) put(8'(8'h11 * (i + 1)));
    chk("lim56_rdy", ByteInReady, 1);
    put(8'h88);
    chk("lim64_cnt", BitCount, 64);
    chk("lim64_rdy", ByteInReady, 0);
    use_bits(7'd7);
    chk("lim57_rdy", ByteInReady, 0);
    use_bits(7'd1);
    chk("lim56b_rdy", ByteInReady, 1);

    init();
    chk("init_err", ErrorOverUse, 1);
    start();
    put(8'hFF); put(8'hD9);
    chk("eoi_code", MarkerCode, 8'hD9);
    chk("eoi_en", DataInEnable, 0);
    MarkerClear = 1'b1;
    step();
    MarkerClear = 1'b0;
    chk("done_run", DataInRun, 0);
    chk("done_rdy", ByteInReady, 0);
    start();
    chk("done_hold", DataInRun, 0);
    init();
    start();
    chk("restart", DataInRun, 1);

    put(8'h42);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_cnt", BitCount, 0);
    chk("mrst_run", DataInRun, 0);
    chk("mrst_err", ErrorOverUse, 0);
    chk("mrst_data", DataIn, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
